// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, op-code map and the legal-op helper.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;
  localparam int ALU_OP_MAX = 9;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd9;

  // True when the op code names a real ALU operation.
  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    return op <= ALU_SRA;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. Produces a one-hot grant (or none) from the two
// request valids; on a tie the requester that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       en_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // Tie-break favours the requester other than last_grant_i.
  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = en_i && valid_i[0] && (!valid_i[1] || last_grant_i);
    grant_o[1] = en_i && valid_i[1] && (!valid_i[0] || !last_grant_i);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0) and the
// branch/address unit (requester 1). The granted request drives the ALU and
// its result is captured into a single response slot owned by the winner.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; ready may depend on valid, valid must never depend on ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W,
  parameter int OP_MAX = ALU_OP_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp0_zero,
  output logic              rsp1_zero,
  output logic              rsp0_err,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  localparam logic [OP_W-1:0] OP_MAX_V = OP_W'(OP_MAX);

  logic              slot_valid_q,  slot_valid_d;
  logic              slot_owner_q,  slot_owner_d;
  logic [DATA_W-1:0] slot_result_q, slot_result_d;
  logic              slot_zero_q,   slot_zero_d;
  logic              slot_err_q,    slot_err_d;
  logic              last_grant_q,  last_grant_d;

  logic              drain;
  logic              free;
  logic              arb_en;
  logic [1:0]        grant;
  logic              sel;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              op_illegal;

  // Response decode: slot contents are shown only to the owning requester.
  always_comb begin
    rsp0_valid  = slot_valid_q && !slot_owner_q;
    rsp1_valid  = slot_valid_q &&  slot_owner_q;
    rsp0_result = rsp0_valid ? slot_result_q : '0;
    rsp1_result = rsp1_valid ? slot_result_q : '0;
    rsp0_zero   = rsp0_valid && slot_zero_q;
    rsp1_zero   = rsp1_valid && slot_zero_q;
    rsp0_err    = rsp0_valid && slot_err_q;
    rsp1_err    = rsp1_valid && slot_err_q;
    drain       = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    // A draining slot can take the next request in the same cycle; nothing is
    // granted while reset is asserted.
    free        = !slot_valid_q || drain;
    arb_en      = free && rst_n;
  end

  rr_arb2 u_rr_arb2 (
    .valid_i      ({req1_valid, req0_valid}),
    .en_i         (arb_en),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Steer the granted request onto the ALU; idle ALU inputs are held at zero.
  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
    sel        = grant[1];
    sel_op     = sel ? req1_op : req0_op;
    sel_a      = sel ? req1_a  : req0_a;
    sel_b      = sel ? req1_b  : req0_b;
    op_illegal = sel_op > OP_MAX_V;
    alu_in0    = '0;
    alu_in1    = '0;
    alu_op     = '0;
    if (|grant) begin
      alu_in0 = sel_a;
      alu_in1 = sel_b;
      alu_op  = op_illegal ? '0 : sel_op;
    end
  end

  // Slot next state: accept loads the slot, a bare drain just empties it.
  always_comb begin
    slot_valid_d  = slot_valid_q;
    slot_owner_d  = slot_owner_q;
    slot_result_d = slot_result_q;
    slot_zero_d   = slot_zero_q;
    slot_err_d    = slot_err_q;
    last_grant_d  = last_grant_q;
    if (|grant) begin
      slot_valid_d  = 1'b1;
      slot_owner_d  = sel;
      last_grant_d  = sel;
      slot_result_d = op_illegal ? '0 : alu_result;
      slot_zero_d   = op_illegal ? 1'b1 : alu_zero;
      slot_err_d    = op_illegal;
    end else if (drain) begin
      slot_valid_d  = 1'b0;
    end
  end

  // State registers; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q  <= 1'b0;
      slot_owner_q  <= 1'b0;
      slot_result_q <= '0;
      slot_zero_q   <= 1'b0;
      slot_err_q    <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      slot_valid_q  <= slot_valid_d;
      slot_owner_q  <= slot_owner_d;
      slot_result_q <= slot_result_d;
      slot_zero_q   <= slot_zero_d;
      slot_err_q    <= slot_err_d;
      last_grant_q  <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: random requesters with valid held until accepted,
// a combinational ALU model behind the DUT, a transaction-level reference
// model and an expected-response queue checked by a negedge monitor.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int EW = 1 + DW + 1 + 1; // {owner, result, zero, err}

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OW-1:0] req0_op, req1_op;
  logic [DW-1:0] req0_a, req1_a, req0_b, req1_b;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic          rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [DW-1:0] alu_in0, alu_in1, alu_result;
  logic [OW-1:0] alu_op;
  logic          alu_zero;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- ALU arithmetic ----------------
  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return DW'(a < b);
      4'd6:    return DW'($signed(a) < $signed(b));
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

  // The shared ALU sitting behind the arbiter.
  always_comb begin
    alu_result = alu_f(alu_op, alu_in0, alu_in1);
    alu_zero   = (alu_result == '0);
  end

  // Expected response for a request: illegal ops report err with zero result.
  function automatic logic [EW-1:0] expect_rsp(input logic owner, input logic [OW-1:0] op,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    if (op > 4'd9) return {owner, {DW{1'b0}}, 1'b1, 1'b1};
    r = alu_f(op, a, b);
    return {owner, r, (r == '0), 1'b0};
  endfunction

  // ---------------- scoreboard bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver controls ----------------
  int            pv0, pv1, pr0, pr1;
  logic          fix0, fix1;
  logic [OW-1:0] f0_op, f1_op;
  logic [DW-1:0] f0_a, f0_b, f1_a, f1_b;
  logic          took0, took1;

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return DW'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Requesters: hold a request until accepted, then maybe issue a new one.
  initial begin
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!req0_valid || took0) begin
        req0_valid = ($urandom_range(1, 100) <= pv0);
        req0_op    = fix0 ? f0_op : OW'($urandom_range(0, 12));
        req0_a     = fix0 ? f0_a  : rand_operand();
        req0_b     = fix0 ? f0_b  : rand_operand();
      end
      if (!req1_valid || took1) begin
        req1_valid = ($urandom_range(1, 100) <= pv1);
        req1_op    = fix1 ? f1_op : OW'($urandom_range(0, 12));
        req1_a     = fix1 ? f1_a  : rand_operand();
        req1_b     = fix1 ? f1_b  : rand_operand();
      end
      rsp0_ready = ($urandom_range(1, 100) <= pr0);
      rsp1_ready = ($urandom_range(1, 100) <= pr1);
    end
  end

  // ---------------- reference model + monitor ----------------
  // Transaction view: one slot, its owner, and who won the last arbitration.
  logic          m_full, m_owner, m_last;
  logic          m_drain, m_free, m_gv, m_g;
  logic [EW-1:0] front;
  logic [OW-1:0] g_op;
  logic [DW-1:0] g_a, g_b;

  // Sampled mid-cycle, while inputs and outputs are both settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req0_ready", 64'(req0_ready), 64'd0);
      check("rst_req1_ready", 64'(req1_ready), 64'd0);
      check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
      check("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
      check("rst_alu_op",     64'(alu_op),     64'd0);
      check("rst_rsp_result", 64'(rsp0_result | rsp1_result), 64'd0);
      m_full = 0; m_owner = 0; m_last = 1;
      exp_q.delete();
      took0 = 0; took1 = 0;
    end else begin
      m_drain = m_full && (m_owner ? rsp1_ready : rsp0_ready);
      m_free  = !m_full || m_drain;
      m_gv    = m_free && (req0_valid || req1_valid);
      if (req0_valid && req1_valid) m_g = !m_last;
      else                          m_g = req1_valid;

      check("req0_ready", 64'(req0_ready), 64'(m_gv && !m_g));
      check("req1_ready", 64'(req1_ready), 64'(m_gv &&  m_g));
      check("rsp0_valid", 64'(rsp0_valid), 64'(m_full && !m_owner));
      check("rsp1_valid", 64'(rsp1_valid), 64'(m_full &&  m_owner));

      if (m_full) begin
        if (exp_q.size() == 0) begin
          check("exp_q_nonempty", 64'd0, 64'd1);
        end else begin
          front = exp_q[0];
          if (m_owner) begin
            check("rsp1_result", 64'(rsp1_result), 64'(front[DW+1:2]));
            check("rsp1_zero",   64'(rsp1_zero),   64'(front[1]));
            check("rsp1_err",    64'(rsp1_err),    64'(front[0]));
            check("rsp0_result_idle", 64'(rsp0_result), 64'd0);
          end else begin
            check("rsp0_result", 64'(rsp0_result), 64'(front[DW+1:2]));
            check("rsp0_zero",   64'(rsp0_zero),   64'(front[1]));
            check("rsp0_err",    64'(rsp0_err),    64'(front[0]));
            check("rsp1_result_idle", 64'(rsp1_result), 64'd0);
          end
          if (m_drain) void'(exp_q.pop_front());
        end
      end

      if (m_gv) begin
        g_op = m_g ? req1_op : req0_op;
        g_a  = m_g ? req1_a  : req0_a;
        g_b  = m_g ? req1_b  : req0_b;
        check("alu_op",  64'(alu_op),  64'((g_op > 4'd9) ? 4'd0 : g_op));
        check("alu_in0", 64'(alu_in0), 64'(g_a));
        check("alu_in1", 64'(alu_in1), 64'(g_b));
        exp_q.push_back(expect_rsp(m_g, g_op, g_a, g_b));
        m_full = 1; m_owner = m_g; m_last = m_g;
      end else begin
        check("alu_op_idle", 64'(alu_op), 64'd0);
        if (m_drain) m_full = 0;
      end

      took0 = req0_valid && req0_ready;
      took1 = req1_valid && req1_ready;
    end
  end

  // ---------------- test sequence ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n = 0;
    pv0 = 100; pv1 = 0; pr0 = 100; pr1 = 100;
    fix0 = 1; f0_op = 4'd0; f0_a = 32'h7FFF_FFFF; f0_b = 32'd1;
    fix1 = 1; f1_op = 4'd4; f1_a = 32'hAAAA_AAAA; f1_b = 32'h5555_5555;

    // Reset held with req0 pending, then ADD overflow corner.
    wait_cycles(3);
    rst_n = 1;
    wait_cycles(4);

    // Continuous dual requests: strict alternation.
    f0_op = 4'd1; f0_a = 32'd5; f0_b = 32'd5;
    pv1 = 100;
    wait_cycles(10);

    // Backpressure on requester 1 while requester 0 keeps asking.
    pr1 = 0;
    wait_cycles(6);
    pr1 = 100;
    wait_cycles(4);

    // Illegal op on requester 1, then a legal one.
    pv0 = 0; f1_op = 4'hC;
    wait_cycles(4);
    f1_op = 4'd3;
    wait_cycles(4);

    // Async reset with the slot full.
    pv0 = 100; pv1 = 100; pr0 = 0; pr1 = 0;
    wait_cycles(4);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("async_rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("async_rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    wait_cycles(2);
    pr0 = 100; pr1 = 100;
    rst_n = 1;
    wait_cycles(6);

    // Randomised traffic across a range of load and backpressure mixes.
    fix0 = 0; fix1 = 0;
    for (int k = 0; k < 8; k++) begin
      pv0 = $urandom_range(20, 100); pv1 = $urandom_range(20, 100);
      pr0 = $urandom_range(10, 100); pr1 = $urandom_range(10, 100);
      wait_cycles(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
